// File: rtl/oam_scan_pkg.sv
// oam_scan_pkg: shared constants, state encoding, result slot layout and hit test for the OAM object search
package oam_scan_pkg;
  localparam int OAM_ENTRIES  = 40;
  localparam int MAX_PER_LINE = 10;
  localparam int OBJ_Y_OFFSET = 16;
  localparam int OBJ_H_SMALL  = 8;
  localparam int OBJ_H_LARGE  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_Y,
    S_FETCH_X,
    S_LAST,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [7:0] x;
    logic [5:0] num;
    logic [3:0] row;
  } slot_t;

  // Returns {hit, row}; 9-bit math so Y above ly+16 cannot wrap into a hit
  function automatic logic [4:0] obj_eval(input logic [7:0] ly, input logic [7:0] y, input logic big);
    logic [8:0] t;
    t = {1'b0, ly} + 9'(OBJ_Y_OFFSET) - {1'b0, y};
    return {({1'b0, y} <= {1'b0, ly} + 9'(OBJ_Y_OFFSET)) && (t < 9'(big ? OBJ_H_LARGE : OBJ_H_SMALL)), t[3:0]};
  endfunction
endpackage

// File: rtl/oam_scan_slots.sv
// oam_scan_slots: append-only result register file that saturates at MAX_PER_LINE entries
module oam_scan_slots
  import oam_scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_we,
  input  slot_t      i_slot,
  input  logic [3:0] i_rd_idx,
  output logic [3:0] o_count,
  output slot_t      o_rd
);
  slot_t      r_slots [MAX_PER_LINE];
  logic [3:0] r_count;

  // Clear only rewinds the count; appends past the limit are dropped
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
      for (int i = 0; i < MAX_PER_LINE; i++) r_slots[i] <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_we && r_count < 4'(MAX_PER_LINE)) begin
      r_slots[r_count] <= i_slot;
      r_count          <= r_count + 4'd1;
    end
  end

  assign o_count = r_count;
  assign o_rd    = (i_rd_idx < 4'(MAX_PER_LINE)) ? r_slots[i_rd_idx] : '0;
endmodule

// File: rtl/oam_scan.sv
// oam_scan: mode-2 OAM search that keeps the first MAX_PER_LINE objects covering the current line
module oam_scan
  import oam_scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_start,
  input  logic [7:0] ly,
  input  logic       obj_size,
  input  logic       dma_occupy_oambus,
  output logic [7:0] oam_a,
  output logic       oam_rd,
  input  logic [7:0] oam_din,
  output logic       scan_busy,
  output logic       scan_done,
  output logic [3:0] obj_count,
  input  logic [3:0] rd_idx,
  output logic [7:0] rd_x,
  output logic [5:0] rd_num,
  output logic [3:0] rd_row
);
  state_e     r_state;
  logic [5:0] r_idx;
  logic [7:0] r_y;
  logic [7:0] r_ly;
  logic       r_size;
  logic [7:0] r_oam_a;
  logic       r_oam_rd;
  logic       r_busy;
  logic       r_done;

  logic [7:0] w_byte;
  logic [4:0] w_eval;
  logic       w_we;
  slot_t      w_slot;
  slot_t      w_rd;

  assign w_byte = dma_occupy_oambus ? 8'hFF : oam_din;
  assign w_eval = obj_eval(r_ly, r_y, r_size);
  assign w_we   = w_eval[4] && ((r_state == S_FETCH_Y && r_idx != 6'd0) || r_state == S_LAST);
  assign w_slot = '{x: w_byte, num: (r_state == S_LAST) ? r_idx : r_idx - 6'd1, row: w_eval[3:0]};

  // Scan sequencer: Y and X reads alternate, and each X byte returns while the next Y address goes out
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_y      <= '0;
      r_ly     <= '0;
      r_size   <= 1'b0;
      r_oam_a  <= '0;
      r_oam_rd <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (scan_start) begin
      r_state  <= S_FETCH_Y;
      r_idx    <= '0;
      r_ly     <= ly;
      r_size   <= obj_size;
      r_oam_a  <= 8'h00;
      r_oam_rd <= 1'b1;
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH_Y: begin
          r_state <= S_FETCH_X;
          r_oam_a <= {r_idx, 2'b01};
        end
        S_FETCH_X: begin
          r_y <= w_byte;
          if (r_idx == 6'(OAM_ENTRIES - 1)) begin
            r_state  <= S_LAST;
            r_oam_rd <= 1'b0;
          end else begin
            r_idx   <= r_idx + 6'd1;
            r_state <= S_FETCH_Y;
            r_oam_a <= {r_idx + 6'd1, 2'b00};
          end
        end
        S_LAST: begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  oam_scan_slots u_slots (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (scan_start),
    .i_we     (w_we),
    .i_slot   (w_slot),
    .i_rd_idx (rd_idx),
    .o_count  (obj_count),
    .o_rd     (w_rd)
  );

  assign oam_a     = r_oam_a;
  assign oam_rd    = r_oam_rd;
  assign scan_busy = r_busy;
  assign scan_done = r_done;
  assign rd_x      = w_rd.x;
  assign rd_num    = w_rd.num;
  assign rd_row    = w_rd.row;
endmodule

// File: doc/oam_scan.md
Name: oam_scan

Overview:
PPU mode-2 object search stage, directly downstream of the OAM DMA unit, which fills OAM at 0xFE00–0xFE9F. On each scan_start it reads Y and X for all 40 OAM entries in index order. It keeps the first MAX_PER_LINE objects whose vertical span covers the current line. The results go to the pixel fetcher through an indexed read port.
While DMA owns the OAM bus, OAM bytes read as 0xFF, which matches real hardware behaviour.

Parameters:
NUM_ENTRIES, 40, OAM entries scanned per line
MAX_PER_LINE, 10, maximum objects retained per line

Ports:
clk  in  1  CPU/dot clock
rst  in  1  synchronous, active-low reset (0 = reset)
scan_start  in  1  one-cycle pulse at line start; begins or restarts a scan
ly  in  8  current line; sampled at scan_start
obj_size  in  1  LCDC.2; 0 = 8-line objects, 1 = 16-line; sampled at scan_start
dma_occupy_oambus  in  1  DMA owns OAM; forces captured bytes to 0xFF
oam_a  out  8  OAM byte address (offset within 0xFE00 page)
oam_rd  out  1  OAM read strobe; data valid one cycle after the address
oam_din  in  8  OAM read data (synchronous, 1-cycle latency)
scan_busy  out  1  high while a scan is in progress
scan_done  out  1  one-cycle pulse when the results are final
obj_count  out  4  number of valid result slots (0..MAX_PER_LINE)
rd_idx  in  4  result slot select
rd_x  out  8  X byte of the selected slot (combinational)
rd_num  out  6  OAM index of the selected slot
rd_row  out  4  row within the object for line ly (0..15)

Behaviour:
- Reset values: oam_a=0, oam_rd=0, scan_busy=0, scan_done=0, obj_count=0. All slots clear to 0. State is IDLE.
- States: IDLE, FETCH_Y, FETCH_X, LAST, DONE. Registers: idx[5:0], y_q[7:0], ly_q, size_q.
- IDLE: on scan_start, latch ly and obj_size, clear obj_count and idx, then go to FETCH_Y.
- FETCH_Y:
  - Drive oam_a={idx,2'b00} with oam_rd=1.
  - If idx>0, capture oam_din as the X byte of entry idx-1 and evaluate entry idx-1.
  - Go to FETCH_X.
- FETCH_X:
  - Drive oam_a={idx,2'b01} with oam_rd=1, and capture oam_din into y_q.
  - If idx==NUM_ENTRIES-1, go to LAST. Otherwise idx+1 and go to FETCH_Y.
- LAST: oam_rd=0; capture X and evaluate entry 39; go to DONE.
- DONE: scan_done=1 for one cycle, scan_busy=0 next cycle, go to IDLE.
- scan_busy=1 in FETCH_Y, FETCH_X and LAST.
- Latency: the scan_start edge is edge 0. Fetch occupies cycles 1–80, LAST is cycle 81, and scan_done is high in cycle 82.
- DMA masking: any byte captured while dma_occupy_oambus=1 is treated as 0xFF. Because ly<=153, Y=0xFF never hits.
- Hit rule, 9-bit arithmetic:
  - t = ly_q + 16 − y_q.
  - Hit iff y_q <= ly_q+16 and t < (size_q ? 16 : 8).
  - rd_row = t[3:0].
- Append:
  - On a hit with obj_count<MAX_PER_LINE, write {x, index, row} to slot obj_count and increment obj_count.
  - Hits after saturation are ignored.
  - Slot order is ascending OAM index.
- scan_start while busy: restart immediately, with the same actions as in IDLE, discarding partial results. No scan_done is issued for the aborted scan.
- Results and obj_count hold from scan_done until the next scan_start.
- rd_idx>=obj_count returns stale slot contents; the consumer must gate on obj_count.
- Reset low mid-scan returns everything to reset values on that edge.

Decomposition:
- Shared package:
  - OAM_ENTRIES, MAX_PER_LINE and OBJ_Y_OFFSET=16.
  - Height constants 8 and 16.
  - The state enum encoding.
  - The slot struct {x[7:0], num[5:0], row[3:0]}.
- One sub-module, oam_scan_slots: an append-only register file. It has a clear input, a write-enable that appends at the current count and saturates, a count output and a combinational read port.

Test Plan:
- OAM entry 0 has Y=0x10, X=0x08; ly=0, obj_size=0; scan_start -> scan_done in cycle 82, obj_count=1, slot0 = {x=0x08, num=0, row=0}.
- All 40 entries Y=0x20; ly=0x12 -> obj_count=10, slots hold nums 0..9 with row=2; entries 10–39 dropped.
- Entry 5 Y=0x18, ly=0x10: obj_size=0 gives row 8 -> miss, obj_count=0; obj_size=1 -> hit, row=8, num=5.
- Hold dma_occupy_oambus=1 for the whole scan with all Y=0x20, ly=0x12 -> obj_count=0, scan_done still at cycle 82.
- Issue scan_start again at cycle 40 with ly changed to 0x30 -> no done at 82; done at cycle 40+82; results reflect ly=0x30 only.
- Drive rst=0 at cycle 50 of a scan -> next cycle scan_busy=0, obj_count=0, oam_rd=0; no scan_done until a new scan_start.
